// File: rtl/cfs_rx_ctrl.sv
// cfs_rx_ctrl: RX controller between the MD RX slave interface and the RX FIFO.
// Checks each MD transfer's offset/size pair against the data width. Legal
// transfers are pushed into the RX FIFO. Illegal ones get an error response
// and are counted in a saturating drop counter.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   md_rx_valid       MD transfer request (held by master until md_rx_ready)
//   md_rx_data        MD transfer data
//   md_rx_offset      byte offset of valid data
//   md_rx_size        number of valid bytes
//   md_rx_ready       one-cycle transfer completion pulse
//   md_rx_err         error response, qualified by md_rx_ready
//   push_valid        RX FIFO push request
//   push_data         captured md_rx_data
//   push_offset       captured md_rx_offset
//   push_size         captured md_rx_size
//   push_ready        RX FIFO can accept
//   ctrl_clr          one-cycle pulse clearing the drop counter
//   status_cnt_drop   dropped-transfer count (saturating)
//   max_drop          high while status_cnt_drop is all-ones
module cfs_rx_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CNT_DROP_WIDTH = 8,
  localparam int unsigned OFFSET_WIDTH  = (DATA_WIDTH <= 8) ? 1 : $clog2(DATA_WIDTH / 8),
  localparam int unsigned SIZE_WIDTH    = $clog2(DATA_WIDTH / 8) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      md_rx_valid,
  input  logic [DATA_WIDTH-1:0]     md_rx_data,
  input  logic [OFFSET_WIDTH-1:0]   md_rx_offset,
  input  logic [SIZE_WIDTH-1:0]     md_rx_size,
  output logic                      md_rx_ready,
  output logic                      md_rx_err,
  output logic                      push_valid,
  output logic [DATA_WIDTH-1:0]     push_data,
  output logic [OFFSET_WIDTH-1:0]   push_offset,
  output logic [SIZE_WIDTH-1:0]     push_size,
  input  logic                      push_ready,
  input  logic                      ctrl_clr,
  output logic [CNT_DROP_WIDTH-1:0] status_cnt_drop,
  output logic                      max_drop
);

  // One extra bit so offset+size and B+offset cannot overflow.
  localparam int unsigned SUM_WIDTH = SIZE_WIDTH + 1;
  localparam logic [SUM_WIDTH-1:0] BYTES_S = SUM_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic                        ready_q, ready_d;
  logic                        err_q, err_d;
  logic                        push_valid_q, push_valid_d;
  logic [DATA_WIDTH-1:0]       data_q, data_d;
  logic [OFFSET_WIDTH-1:0]     offset_q, offset_d;
  logic [SIZE_WIDTH-1:0]       size_q, size_d;
  logic [CNT_DROP_WIDTH-1:0]   cnt_q, cnt_d;
  logic                        max_q, max_d;
  logic                        drop_inc;

  logic [SUM_WIDTH-1:0]        off_s, size_s, mod_s;
  logic                        legal;

  // Legality of the offset/size pair currently on the MD interface.
  always_comb begin
    off_s  = SUM_WIDTH'(md_rx_offset);
    size_s = SUM_WIDTH'(md_rx_size);
    // Guard the modulo so a zero size never divides by zero.
    mod_s  = (size_s == '0) ? '0 : ((BYTES_S + off_s) % size_s);
    legal  = (size_s != '0) && (mod_s == '0) && ((off_s + size_s) <= BYTES_S);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ready_d      = 1'b0;
    err_d        = 1'b0;
    push_valid_d = push_valid_q;
    data_d       = data_q;
    offset_d     = offset_q;
    size_d       = size_q;
    drop_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        push_valid_d = 1'b0;
        if (md_rx_valid) begin
          data_d   = md_rx_data;
          offset_d = md_rx_offset;
          size_d   = md_rx_size;
          if (legal) begin
            state_d      = PUSH;
            push_valid_d = 1'b1;
          end else begin
            state_d  = RESP;
            ready_d  = 1'b1;
            err_d    = 1'b1;
            drop_inc = 1'b1;
          end
        end
      end
      PUSH: begin
        // Stall here indefinitely while the FIFO is full.
        if (push_ready) begin
          state_d      = RESP;
          push_valid_d = 1'b0;
          ready_d      = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        push_valid_d = 1'b0;
      end
    endcase
  end

  // Saturating drop counter; a clear beats a simultaneous increment.
  always_comb begin
    cnt_d = cnt_q;
    if (ctrl_clr) begin
      cnt_d = '0;
    end else if (drop_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_DROP_WIDTH'(1);
    end
    max_d = (cnt_d == '1);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      push_valid_q <= 1'b0;
      data_q       <= '0;
      offset_q     <= '0;
      size_q       <= '0;
      cnt_q        <= '0;
      max_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      push_valid_q <= push_valid_d;
      data_q       <= data_d;
      offset_q     <= offset_d;
      size_q       <= size_d;
      cnt_q        <= cnt_d;
      max_q        <= max_d;
    end
  end

  assign md_rx_ready     = ready_q;
  assign md_rx_err       = err_q;
  assign push_valid      = push_valid_q;
  assign push_data       = data_q;
  assign push_offset     = offset_q;
  assign push_size       = size_q;
  assign status_cnt_drop = cnt_q;
  assign max_drop        = max_q;

endmodule

// File: tb/tb_cfs_rx_ctrl.sv
// Directed self-checking bench for cfs_rx_ctrl at DATA_WIDTH=32.
module tb_cfs_rx_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned OW = 2;
  localparam int unsigned SW = 3;

  logic          clk;
  logic          reset;
  logic          md_rx_valid;
  logic [DW-1:0] md_rx_data;
  logic [OW-1:0] md_rx_offset;
  logic [SW-1:0] md_rx_size;
  logic          md_rx_ready;
  logic          md_rx_err;
  logic          push_valid;
  logic [DW-1:0] push_data;
  logic [OW-1:0] push_offset;
  logic [SW-1:0] push_size;
  logic          push_ready;
  logic          ctrl_clr;
  logic [CW-1:0] status_cnt_drop;
  logic          max_drop;

  int checks   = 0;
  int failures = 0;

  cfs_rx_ctrl #(
    .DATA_WIDTH     (DW),
    .CNT_DROP_WIDTH (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .md_rx_valid     (md_rx_valid),
    .md_rx_data      (md_rx_data),
    .md_rx_offset    (md_rx_offset),
    .md_rx_size      (md_rx_size),
    .md_rx_ready     (md_rx_ready),
    .md_rx_err       (md_rx_err),
    .push_valid      (push_valid),
    .push_data       (push_data),
    .push_offset     (push_offset),
    .push_size       (push_size),
    .push_ready      (push_ready),
    .ctrl_clr        (ctrl_clr),
    .status_cnt_drop (status_cnt_drop),
    .max_drop        (max_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic [OW-1:0] o, input logic [SW-1:0] s);
    md_rx_valid  = 1'b1;
    md_rx_data   = d;
    md_rx_offset = o;
    md_rx_size   = s;
  endtask

  initial begin
    logic [CW-1:0] exp_cnt;

    reset        = 1'b1;
    md_rx_valid  = 1'b0;
    md_rx_data   = '0;
    md_rx_offset = '0;
    md_rx_size   = '0;
    push_ready   = 1'b0;
    ctrl_clr     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_ready", 64'(md_rx_ready), 64'd0);
    chk("rst_err", 64'(md_rx_err), 64'd0);
    chk("rst_push_valid", 64'(push_valid), 64'd0);
    chk("rst_push_data", 64'(push_data), 64'd0);
    chk("rst_push_offset", 64'(push_offset), 64'd0);
    chk("rst_push_size", 64'(push_size), 64'd0);
    chk("rst_cnt", 64'(status_cnt_drop), 64'd0);
    chk("rst_max", 64'(max_drop), 64'd0);

    // 1. Legal push, FIFO ready
    push_ready = 1'b1;
    drive(32'hAABBCCDD, 2'd0, 3'd4);
    tick();
    chk("t1_push_valid", 64'(push_valid), 64'd1);
    chk("t1_push_data", 64'(push_data), 64'hAABBCCDD);
    chk("t1_push_offset", 64'(push_offset), 64'd0);
    chk("t1_push_size", 64'(push_size), 64'd4);
    chk("t1_ready_early", 64'(md_rx_ready), 64'd0);
    tick();
    chk("t1_push_valid_low", 64'(push_valid), 64'd0);
    chk("t1_ready", 64'(md_rx_ready), 64'd1);
    chk("t1_err", 64'(md_rx_err), 64'd0);
    md_rx_valid = 1'b0;
    tick();
    chk("t1_ready_drop", 64'(md_rx_ready), 64'd0);
    chk("t1_cnt", 64'(status_cnt_drop), 64'd0);

    // 2. Illegal size zero
    drive(32'h11223344, 2'd0, 3'd0);
    tick();
    chk("t2_ready", 64'(md_rx_ready), 64'd1);
    chk("t2_err", 64'(md_rx_err), 64'd1);
    chk("t2_push_valid", 64'(push_valid), 64'd0);
    chk("t2_cnt", 64'(status_cnt_drop), 64'd1);
    md_rx_valid = 1'b0;
    tick();
    chk("t2_ready_drop", 64'(md_rx_ready), 64'd0);
    chk("t2_err_drop", 64'(md_rx_err), 64'd0);

    // 3. Mixed legality from a cleared counter
    ctrl_clr = 1'b1;
    tick();
    ctrl_clr = 1'b0;
    chk("t3_clr", 64'(status_cnt_drop), 64'd0);
    // offset=1 size=2: (4+1)%2 != 0
    drive(32'h01010101, 2'd1, 3'd2);
    tick();
    chk("t3a_err", 64'(md_rx_err), 64'd1);
    chk("t3a_push_valid", 64'(push_valid), 64'd0);
    md_rx_valid = 1'b0;
    tick();
    // offset=2 size=2: legal
    drive(32'h02020202, 2'd2, 3'd2);
    tick();
    chk("t3b_push_valid", 64'(push_valid), 64'd1);
    chk("t3b_push_offset", 64'(push_offset), 64'd2);
    chk("t3b_push_size", 64'(push_size), 64'd2);
    tick();
    chk("t3b_ready", 64'(md_rx_ready), 64'd1);
    chk("t3b_err", 64'(md_rx_err), 64'd0);
    md_rx_valid = 1'b0;
    tick();
    // offset=3 size=2: 3+2 > 4
    drive(32'h03030303, 2'd3, 3'd2);
    tick();
    chk("t3c_err", 64'(md_rx_err), 64'd1);
    chk("t3c_push_valid", 64'(push_valid), 64'd0);
    md_rx_valid = 1'b0;
    tick();
    // offset=1 size=1: legal
    drive(32'h04040404, 2'd1, 3'd1);
    tick();
    chk("t3d_push_valid", 64'(push_valid), 64'd1);
    tick();
    chk("t3d_err", 64'(md_rx_err), 64'd0);
    md_rx_valid = 1'b0;
    tick();
    // offset=0 size=3: 4%3 != 0
    drive(32'h05050505, 2'd0, 3'd3);
    tick();
    chk("t3e_err", 64'(md_rx_err), 64'd1);
    md_rx_valid = 1'b0;
    tick();
    chk("t3_cnt", 64'(status_cnt_drop), 64'd3);

    // 4. Backpressure: push_ready low for 5 sampled edges
    push_ready = 1'b0;
    drive(32'h12345678, 2'd0, 3'd4);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("t4_push_valid_hold", 64'(push_valid), 64'd1);
      chk("t4_push_data_hold", 64'(push_data), 64'h12345678);
      chk("t4_push_size_hold", 64'(push_size), 64'd4);
      chk("t4_ready_hold", 64'(md_rx_ready), 64'd0);
      if (i < 5) tick();
    end
    push_ready = 1'b1;
    tick();
    chk("t4_push_valid_done", 64'(push_valid), 64'd0);
    chk("t4_ready", 64'(md_rx_ready), 64'd1);
    chk("t4_err", 64'(md_rx_err), 64'd0);
    md_rx_valid = 1'b0;
    tick();
    chk("t4_push_valid_after", 64'(push_valid), 64'd0);
    chk("t4_cnt", 64'(status_cnt_drop), 64'd3);

    // 5. Saturation over 260 drops, then clear
    ctrl_clr = 1'b1;
    tick();
    ctrl_clr = 1'b0;
    chk("t5_clr0", 64'(status_cnt_drop), 64'd0);
    for (int k = 1; k <= 260; k++) begin
      drive(32'hDEAD0000, 2'd0, 3'd0);
      tick();
      exp_cnt = (k >= 255) ? 8'd255 : 8'(k);
      chk("t5_cnt", 64'(status_cnt_drop), 64'(exp_cnt));
      chk("t5_max", 64'(max_drop), (k >= 255) ? 64'd1 : 64'd0);
      md_rx_valid = 1'b0;
      tick();
    end
    ctrl_clr = 1'b1;
    tick();
    ctrl_clr = 1'b0;
    chk("t5_clr_cnt", 64'(status_cnt_drop), 64'd0);
    chk("t5_clr_max", 64'(max_drop), 64'd0);

    // 6a. Clear wins over a simultaneous increment
    drive(32'h0, 2'd0, 3'd0);
    tick();
    md_rx_valid = 1'b0;
    tick();
    chk("t6a_pre_cnt", 64'(status_cnt_drop), 64'd1);
    drive(32'h0, 2'd0, 3'd0);
    ctrl_clr = 1'b1;
    tick();
    ctrl_clr = 1'b0;
    chk("t6a_err", 64'(md_rx_err), 64'd1);
    chk("t6a_cnt", 64'(status_cnt_drop), 64'd0);
    md_rx_valid = 1'b0;
    tick();
    chk("t6a_cnt_after", 64'(status_cnt_drop), 64'd0);

    // 6b. Reset while stalled in PUSH
    drive(32'h0, 2'd0, 3'd0);
    tick();
    md_rx_valid = 1'b0;
    tick();
    chk("t6b_pre_cnt", 64'(status_cnt_drop), 64'd1);
    push_ready = 1'b0;
    drive(32'hCAFEF00D, 2'd0, 3'd4);
    tick();
    chk("t6b_in_push", 64'(push_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6b_async_push_valid", 64'(push_valid), 64'd0);
    chk("t6b_async_cnt", 64'(status_cnt_drop), 64'd0);
    chk("t6b_async_ready", 64'(md_rx_ready), 64'd0);
    md_rx_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("t6b_no_ready", 64'(md_rx_ready), 64'd0);
    chk("t6b_push_valid_idle", 64'(push_valid), 64'd0);
    // Back in IDLE: a new legal transfer is accepted immediately.
    push_ready = 1'b1;
    drive(32'h0BADBEEF, 2'd0, 3'd4);
    tick();
    chk("t6b_idle_push", 64'(push_valid), 64'd1);
    chk("t6b_idle_data", 64'(push_data), 64'h0BADBEEF);
    tick();
    chk("t6b_idle_ready", 64'(md_rx_ready), 64'd1);
    md_rx_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
